// File: rtl/data_mem_responder_if.sv
// Load/store bus between the datapath and the data-memory responder.
// master: MemRead/MemWrite/ALUResult/WriteData out; slave: ReadData/rvalid/stall/misaligned out.
interface data_mem_responder_if;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        rvalid;
  logic        stall;
  logic        misaligned;

  modport master (
    output MemRead, MemWrite, ALUResult, WriteData,
    input  ReadData, rvalid, stall, misaligned
  );

  modport slave (
    input  MemRead, MemWrite, ALUResult, WriteData,
    output ReadData, rvalid, stall, misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: wait-stated byte/half/word stores and aligned word loads.
// Ports: clk, reset (async, active low), bus (slave); DMEM_PERF_EN adds rd_count/wr_count.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef DMEM_PERF_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] l_addr;
  logic [31:0] l_data;
  logic [1:0]  l_size;
  logic        l_st;

  logic [31:0] mem [DEPTH_WORDS];

  logic        is_st;
  logic        req;
  assign is_st = bus.MemWrite != 2'b00;
  assign req   = bus.MemRead | is_st;

  // With zero wait states the access completes straight from IDLE,
  // so the live inputs are used; otherwise the latched copy.
  logic [31:0] c_addr;
  logic [31:0] c_data;
  logic [1:0]  c_size;
  logic        c_st;
  always_comb begin
    c_addr = l_addr;
    c_data = l_data;
    c_size = l_size;
    c_st   = l_st;
    if (state == S_IDLE) begin
      c_addr = bus.ALUResult;
      c_data = bus.WriteData;
      c_size = is_st ? bus.MemWrite : 2'b11;
      c_st   = is_st;
    end
  end

  logic unused_addr;
  assign unused_addr = ^c_addr[31:AW+2];

  logic [AW-1:0] idx;
  assign idx = c_addr[AW+1:2];

  // Loads carry size 11, so they get the word alignment check.
  logic c_mis;
  assign c_mis = (c_size == 2'b10 && c_addr[0])
              || (c_size == 2'b11 && c_addr[1:0] != 2'b00);

  logic go;
  assign go = (state == S_IDLE && req && WAIT_STATES == 0)
           || (state == S_WAIT && cnt == 4'd1);

  logic [3:0]  be;
  logic [31:0] wd;
  always_comb begin
    be = 4'b0000;
    wd = c_data;
    unique case (1'b1)
      c_size == 2'b01: begin
        be = 4'b0001 << c_addr[1:0];
        wd = {4{c_data[7:0]}};
      end
      c_size == 2'b10: begin
        be = c_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{c_data[15:0]}};
      end
      c_size == 2'b11: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Gated by reset so an access cut short by reset never lands.
  logic we;
  assign we = go && c_st && !c_mis && reset;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign bus.stall = reset && ((state == S_IDLE) ? req : (state == S_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      l_addr         <= '0;
      l_data         <= '0;
      l_size         <= '0;
      l_st           <= 1'b0;
      bus.rvalid     <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.ReadData   <= '0;
    end else begin
      bus.rvalid     <= 1'b0;
      bus.misaligned <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            l_addr <= bus.ALUResult;
            l_data <= bus.WriteData;
            l_size <= is_st ? bus.MemWrite : 2'b11;
            l_st   <= is_st;
            cnt    <= 4'(WAIT_STATES);
            state  <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go) begin
        bus.misaligned <= c_mis;
        bus.rvalid     <= !c_st;
        if (!c_st) bus.ReadData <= c_mis ? '0 : mem[idx];
      end
    end
  end

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (go && !c_mis) begin
      if (c_st && wr_count != '1) wr_count <= wr_count + 32'd1;
      if (!c_st && rd_count != '1) rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table, corner sequences, random vs model.
// Two instances: u0 with one wait state, u1 with none; sel picks the one being driven.
module tb_data_mem_responder;
  localparam int DW = 1024;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bit          sel = 1'b0;
  logic        mr = 1'b0;
  logic [1:0]  mw = 2'b00;
  logic [31:0] aa = '0;
  logic [31:0] wdat = '0;

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();

  assign b0.MemRead   = !sel && mr;
  assign b0.MemWrite  = sel ? 2'b00 : mw;
  assign b0.ALUResult = aa;
  assign b0.WriteData = wdat;
  assign b1.MemRead   = sel && mr;
  assign b1.MemWrite  = sel ? mw : 2'b00;
  assign b1.ALUResult = aa;
  assign b1.WriteData = wdat;

  logic        s_stall, s_rv, s_mis;
  logic [31:0] s_rd;
  assign s_stall = sel ? b1.stall : b0.stall;
  assign s_rv    = sel ? b1.rvalid : b0.rvalid;
  assign s_mis   = sel ? b1.misaligned : b0.misaligned;
  assign s_rd    = sel ? b1.ReadData : b0.ReadData;

`ifdef DMEM_PERF_EN
  logic [31:0] rc0, wc0, rc1, wc1;
`endif

  data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(1)) u0 (
    .clk(clk),
    .reset(reset),
`ifdef DMEM_PERF_EN
    .rd_count(rc0),
    .wr_count(wc0),
`endif
    .bus(b0)
  );

  data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) u1 (
    .clk(clk),
    .reset(reset),
`ifdef DMEM_PERF_EN
    .rd_count(rc1),
    .wr_count(wc1),
`endif
    .bus(b1)
  );

  logic [31:0] mm [2][DW];
  bit          kn [2][DW];
  logic [31:0] lrd [2];
  bit          lrd_ok [2];
  int          erc, ewc;
  int          checks = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_mis(input bit st, input bit [1:0] sz, input bit [31:0] a);
    int s;
    s = st ? int'(sz) : 3;
    if (s == 2) return (a % 2) != 0;
    if (s == 3) return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic m_store(input bit d, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] w);
    int idx;
    int sh;
    logic [31:0] mask, val;
    idx = int'((a / 4) % DW);
    if (sz == 2'd1) begin
      sh = int'(a % 4) * 8;
      mask = 32'hFF << sh;
      val = (w % 256) << sh;
    end else if (sz == 2'd2) begin
      sh = int'((a % 4) / 2) * 16;
      mask = 32'hFFFF << sh;
      val = (w % 65536) << sh;
    end else begin
      mask = '1;
      val = w;
    end
    mm[d][idx] = (mm[d][idx] & ~mask) | (val & mask);
    if (sz == 2'd3) kn[d][idx] = 1'b1;
  endtask

  task automatic access(input bit d, input bit st, input bit both,
                        input bit [1:0] sz, input bit [31:0] a,
                        input bit [31:0] w,
                        output logic [31:0] rdo, output bit miso);
    int n;
    int idx;
    bit em;
    em = m_mis(st, sz, a);
    idx = int'((a / 4) % DW);
    @(negedge clk);
    sel = d;
    mr = !st || both;
    mw = st ? sz : 2'b00;
    aa = a;
    wdat = w;
    #1;
    n = 0;
    while (s_stall && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", n, d ? 1 : 2);
    rdo = s_rd;
    miso = s_mis;
    chk("misaligned", {31'b0, s_mis}, {31'b0, em});
    chk("rvalid", {31'b0, s_rv}, {31'b0, !st});
    if (st) begin
      if (!em) m_store(d, sz, a, w);
      if (lrd_ok[d]) chk("rdata_hold", s_rd, lrd[d]);
    end else if (em) begin
      chk("rdata_mis", s_rd, 32'h0);
      lrd[d] = '0;
      lrd_ok[d] = 1'b1;
    end else if (kn[d][idx]) begin
      chk("rdata", s_rd, mm[d][idx]);
      lrd[d] = mm[d][idx];
      lrd_ok[d] = 1'b1;
    end else begin
      lrd_ok[d] = 1'b0;
    end
    if (!d && !em) begin
      if (st) ewc++;
      else erc++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    mr = 1'b0;
    mw = 2'b00;
    #1;
    chk("idle_stall", {31'b0, s_stall}, 32'h0);
    chk("idle_rvalid", {31'b0, s_rv}, 32'h0);
    chk("idle_mis", {31'b0, s_mis}, 32'h0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      lrd[d] = '0;
      lrd_ok[d] = 1'b1;
    end
    erc = 0;
    ewc = 0;
  endtask

  typedef struct {
    bit          st;
    bit          both;
    bit [1:0]    sz;
    bit [31:0]   addr;
    bit [31:0]   data;
    bit [31:0]   exp_rd;
    bit          exp_mis;
  } vec_t;

  vec_t vt [$];
  logic [31:0] rd;
  bit mis;

  initial begin
    vt.push_back('{1, 0, 3, 32'h10, 32'hDEADBEEF, 0, 0});
    vt.push_back('{0, 0, 0, 32'h10, 0, 32'hDEADBEEF, 0});
    vt.push_back('{1, 0, 3, 32'h10, 32'h11223344, 0, 0});
    vt.push_back('{1, 0, 1, 32'h13, 32'h000000AA, 0, 0});
    vt.push_back('{0, 0, 0, 32'h10, 0, 32'hAA223344, 0});
    vt.push_back('{1, 0, 2, 32'h10, 32'h00005566, 0, 0});
    vt.push_back('{0, 0, 0, 32'h10, 0, 32'hAA225566, 0});
    vt.push_back('{1, 0, 3, 32'h12, 32'h99999999, 0, 1});
    vt.push_back('{0, 0, 0, 32'h10, 0, 32'hAA225566, 0});
    vt.push_back('{0, 0, 0, 32'h11, 0, 32'h0, 1});
    vt.push_back('{1, 0, 2, 32'h12, 32'hFFFF7788, 0, 0});
    vt.push_back('{1, 0, 2, 32'h11, 32'h0000EEEE, 0, 1});
    vt.push_back('{1, 0, 1, 32'h10, 32'hFFFFFF01, 0, 0});
    vt.push_back('{0, 0, 0, 32'h10, 0, 32'h77885501, 0});
    vt.push_back('{1, 1, 3, 32'h14, 32'hCAFEF00D, 0, 0});
    vt.push_back('{0, 0, 0, 32'h14, 0, 32'hCAFEF00D, 0});

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'b0, b0.stall}, 32'h0);
    chk("rst_rvalid", {31'b0, b0.rvalid}, 32'h0);
    chk("rst_mis", {31'b0, b0.misaligned}, 32'h0);
    chk("rst_rdata0", b0.ReadData, 32'h0);
    chk("rst_rdata1", b1.ReadData, 32'h0);
    reset = 1'b1;

    foreach (vt[i]) begin
      access(0, vt[i].st, vt[i].both, vt[i].sz, vt[i].addr, vt[i].data, rd, mis);
      chk("vec_mis", {31'b0, mis}, {31'b0, vt[i].exp_mis});
      if (!vt[i].st) chk("vec_rd", rd, vt[i].exp_rd);
    end
    idle();

    access(1, 1, 0, 3, 32'h40, 32'hA0A0A0A0, rd, mis);
    access(1, 1, 0, 3, 32'h44, 32'hB1B1B1B1, rd, mis);
    access(1, 1, 0, 3, 32'h48, 32'hC2C2C2C2, rd, mis);
    access(1, 0, 0, 0, 32'h40, 0, rd, mis);
    chk("b2b_ld0", rd, 32'hA0A0A0A0);
    access(1, 0, 0, 0, 32'h44, 0, rd, mis);
    chk("b2b_ld1", rd, 32'hB1B1B1B1);
    access(1, 0, 0, 0, 32'h48, 0, rd, mis);
    chk("b2b_ld2", rd, 32'hC2C2C2C2);
    idle();

    access(0, 1, 0, 3, 32'h20, 32'h0, rd, mis);
    idle();
    @(negedge clk);
    sel = 1'b0;
    mr = 1'b0;
    mw = 2'b11;
    aa = 32'h20;
    wdat = 32'hFFFFFFFF;
    #1;
    chk("mid_stall_idle", {31'b0, s_stall}, 32'h1);
    @(negedge clk);
    #1;
    chk("mid_stall_wait", {31'b0, s_stall}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_stall_drop", {31'b0, s_stall}, 32'h0);
    chk("mid_rvalid", {31'b0, s_rv}, 32'h0);
    mw = 2'b00;
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    access(0, 1, 0, 3, 32'h1004, 32'h12345678, rd, mis);
    access(0, 0, 0, 0, 32'h0004, 0, rd, mis);
    chk("wrap_rd", rd, 32'h12345678);
`ifdef DMEM_PERF_EN
    chk("perf_rd1", rc0, 32'd1);
    chk("perf_wr1", wc0, 32'd1);
`endif
    access(0, 0, 0, 0, 32'h20, 0, rd, mis);
    chk("mid_dropped", rd, 32'h0);

    for (int i = 0; i < 16; i++)
      access(0, 1, 0, 3, 32'(i * 4), $urandom, rd, mis);
    for (int i = 0; i < 300; i++) begin
      bit [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      access(0, 1'($urandom % 2), 1'($urandom % 2), 2'($urandom_range(1, 3)),
             a, $urandom, rd, mis);
      if ($urandom % 4 == 0) idle();
    end
    idle();
`ifdef DMEM_PERF_EN
    chk("perf_rd", rc0, 32'(erc));
    chk("perf_wr", wc0, 32'(ewc));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
